// File: rtl/i2s_rx.sv
// I2S receiver: oversamples SCLK/LRCLK/SD in the i_mclk domain and emits one {left, right} pair per frame.
// Latency: o_valid rises SYNC_STAGES+2 i_mclk cycles after the SCLK pin edge that completes the frame.
// Backpressure: valid/ready; a frame arriving while one is still unconsumed is dropped and o_overrun sticks. Define I2S_RX_LEFT_JUSTIFIED_EN for left-justified format.
module i2s_rx #(
   parameter int DATA_WIDTH  = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    i_mclk,
   input  logic                    i_mclk_rst,
   input  logic                    i_sclk,
   input  logic                    i_lrclk,
   input  logic                    i_sd,
   input  logic                    i_ready,
   output logic [2*DATA_WIDTH-1:0] o_rx_data,
   output logic                    o_valid,
   output logic                    o_overrun,
   output logic                    o_locked
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
   localparam bit LEFT_JUST = 1'b1;
`else
   localparam bit LEFT_JUST = 1'b0;
`endif

   typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;
   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sr, lrclk_sr, sd_sr;
   logic                   sclk_s, lrclk_s, sd_s;
   logic                   sclk_d, lr_prev;
   logic                   rise, boundary;
   logic                   bnd_q, bnd_lr, bnd_sd;
   logic [CW-1:0]          cnt;
   logic [DATA_WIDTH-1:0]  shreg, left_hold;
   logic                   latch_left, frame_done;

   assign sclk_s   = sclk_sr[SYNC_STAGES-1];
   assign lrclk_s  = lrclk_sr[SYNC_STAGES-1];
   assign sd_s     = sd_sr[SYNC_STAGES-1];
   assign rise     = sclk_s & ~sclk_d;
   assign boundary = rise & (lrclk_s ^ lr_prev);

   // Slot boundaries are acted on one cycle after the edge, so the shift register
   // already holds the bit sampled on that edge when the word is taken.
   always_ff @(posedge i_mclk) begin
      if (i_mclk_rst) begin
         sclk_sr  <= '0;
         lrclk_sr <= '0;
         sd_sr    <= '0;
         sclk_d   <= 1'b0;
         lr_prev  <= 1'b0;
         bnd_q    <= 1'b0;
         bnd_lr   <= 1'b0;
         bnd_sd   <= 1'b0;
         cnt      <= '0;
         shreg    <= '0;
      end else begin
         sclk_sr  <= {sclk_sr[SYNC_STAGES-2:0], i_sclk};
         lrclk_sr <= {lrclk_sr[SYNC_STAGES-2:0], i_lrclk};
         sd_sr    <= {sd_sr[SYNC_STAGES-2:0], i_sd};
         sclk_d   <= sclk_s;
         bnd_q    <= boundary;
         if (rise) begin
            lr_prev <= lrclk_s;
            bnd_lr  <= lrclk_s;
            bnd_sd  <= sd_s;
         end
         if (bnd_q) begin
            shreg <= '0;
            if (LEFT_JUST) begin
               shreg[DATA_WIDTH-1] <= bnd_sd;
               cnt                 <= CW'(1);
            end else begin
               cnt <= '0;
            end
         end else if (rise && (cnt < CW'(DATA_WIDTH)) && !(LEFT_JUST && boundary)) begin
            // Bits land directly in their MSB-first position; short slots stay left-aligned.
            for (int i = 0; i < DATA_WIDTH; i++) begin
               if (cnt == CW'(DATA_WIDTH - 1 - i)) shreg[i] <= sd_s;
            end
            cnt <= cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge i_mclk) begin
      if (i_mclk_rst) state <= SYNC;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SYNC:    if (bnd_q && !bnd_lr) state_nxt = LEFT;
         LEFT:    if (bnd_q &&  bnd_lr) state_nxt = RIGHT;
         RIGHT:   if (bnd_q && !bnd_lr) state_nxt = LEFT;
         default: state_nxt = SYNC;
      endcase
   end

   always_comb begin
      latch_left = 1'b0;
      frame_done = 1'b0;
      o_locked   = 1'b0;
      case (state)
         LEFT: begin
            o_locked   = 1'b1;
            latch_left = bnd_q & bnd_lr;
         end
         RIGHT: begin
            o_locked   = 1'b1;
            frame_done = bnd_q & ~bnd_lr;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_mclk) begin
      if (i_mclk_rst) begin
         left_hold <= '0;
         o_rx_data <= '0;
         o_valid   <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         if (latch_left) left_hold <= shreg;
         if (frame_done) begin
            if (!o_valid || i_ready) begin
               o_rx_data <= {left_hold, shreg};
               o_valid   <= 1'b1;
            end else begin
               o_overrun <= 1'b1;
            end
         end else if (i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule
